// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add stage with a registered carry processes one
// operand bit per clock, LSB first, and publishes the whole result at once.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-2:0] res_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       fa_s;
    logic [WIDTH-1:0] res_full_s;
    logic             last_s;
    logic             busy_s;
    logic             done_s;

    // Returns {carry, sum} of a single-bit full addition.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    // Full-add stage, assembled result and last-bit detection.
    always_comb begin
        fa_s       = full_add(a_sh_r[0], b_sh_r[0], carry_r);
        res_full_s = {fa_s[0], res_sh_r};
        last_s     = (cnt_r == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            RUN:     busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_s;
            done <= done_s;
        end
    end

    // Operand capture, serial datapath and result publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {(WIDTH-1){1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            sum      <= {WIDTH{1'b0}};
            cout     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= res_full_s[WIDTH-1:1];
                    carry_r  <= fa_s[1];
                    cnt_r    <= cnt_r + CW'(1);
                    // Only the final bit publishes, so sum/cout never show partials.
                    if (last_s) begin
                        sum  <= res_full_s;
                        cout <= fa_s[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
